// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) burst engines over one word array.
// Define AXI_SLAVE_MEM_DECERR_EN to flag beats past MEM_DEPTH with DECERR instead of wrapping.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int AXI_WIDTH  = 256,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ID_WIDTH-1:0]    S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic [LEN_WIDTH-1:0]   S_AXI_AWLEN,
  input  logic [2:0]             S_AXI_AWSIZE,
  input  logic [1:0]             S_AXI_AWBURST,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [AXI_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                   S_AXI_WLAST,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]    S_AXI_BID,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]    S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic [LEN_WIDTH-1:0]   S_AXI_ARLEN,
  input  logic [2:0]             S_AXI_ARSIZE,
  input  logic [1:0]             S_AXI_ARBURST,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]    S_AXI_RID,
  output logic [AXI_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RLAST,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NB    = AXI_WIDTH / 8;
  localparam int SUM_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [AXI_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [LEN_WIDTH-1:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic                  slverr_q, slverr_d, decerr_q, decerr_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [SUM_W-1:0]      w_sum;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oob, w_last, mem_we;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, r_base;
  logic [LEN_WIDTH-1:0]  rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [LEN_WIDTH:0]    r_off;
  logic [SUM_W-1:0]      r_sum;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_oob;
  logic [AXI_WIDTH-1:0]  rdata_q, rdata_d, r_fetch;
  logic [1:0]            rresp_q, rresp_d;

  // Word index is computed one bit wider than the address so the range check sees the carry.
  assign w_sum = {1'b0, waddr_q} + SUM_W'(wbeat_q);
  assign w_idx = w_sum[IDX_W-1:0];

  // Idle read fetches beat 0 of the incoming AR; during a burst it prefetches the next beat.
  assign r_base = (r_state_q == R_IDLE) ? S_AXI_ARADDR : raddr_q;
  assign r_off  = (r_state_q == R_IDLE) ? '0 : ({1'b0, rbeat_q} + (LEN_WIDTH+1)'(1));
  assign r_sum  = {1'b0, r_base} + SUM_W'(r_off);
  assign r_idx  = r_sum[IDX_W-1:0];

`ifdef AXI_SLAVE_MEM_DECERR_EN
  assign w_oob = (w_sum >= SUM_W'(MEM_DEPTH));
  assign r_oob = (r_sum >= SUM_W'(MEM_DEPTH));
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  assign r_fetch = r_oob ? '0 : mem[r_idx];
  assign w_last  = (wbeat_q == wlen_q);

  assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !ARESET;
  assign S_AXI_WREADY  = (w_state_q == W_DATA);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BID     = wid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (r_state_q == R_IDLE) && !ARESET;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RLAST   = (r_state_q == R_DATA) && (rbeat_q == rlen_q);
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    slverr_d  = slverr_q;
    decerr_d  = decerr_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (S_AXI_AWVALID) begin
        wid_d     = S_AXI_AWID;
        waddr_d   = S_AXI_AWADDR;
        wlen_d    = S_AXI_AWLEN;
        wbeat_d   = '0;
        slverr_d  = 1'b0;
        decerr_d  = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (S_AXI_WVALID) begin
        mem_we   = !w_oob;
        slverr_d = slverr_q | (S_AXI_WLAST != w_last);
        decerr_d = decerr_q | w_oob;
        // Burst length comes from AWLEN; a misplaced WLAST only taints the response.
        if (w_last) begin
          bresp_d   = decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
          w_state_d = W_RESP;
        end else begin
          wbeat_d = wbeat_q + 1'b1;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (S_AXI_ARVALID) begin
        rid_d     = S_AXI_ARID;
        raddr_d   = S_AXI_ARADDR;
        rlen_d    = S_AXI_ARLEN;
        rbeat_d   = '0;
        rdata_d   = r_fetch;
        rresp_d   = r_oob ? 2'b11 : 2'b00;
        r_state_d = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) begin
        if (rbeat_q == rlen_q) begin
          r_state_d = R_IDLE;
        end else begin
          rbeat_d = rbeat_q + 1'b1;
          rdata_d = r_fetch;
          rresp_d = r_oob ? 2'b11 : 2'b00;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      slverr_q  <= slverr_d;
      decerr_q  <= decerr_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Array is never reset; a read of a word written on the same edge sees the old value.
  always_ff @(posedge ACLK) begin
    if (mem_we && !ARESET) begin
      for (int i = 0; i < NB; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_idx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_ARSIZE, S_AXI_ARBURST, w_sum, r_sum};

endmodule
